// File: rtl/led_pkg.sv
// Shared types, LED seed constants and pattern stepping for the LED sequencer.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_CHASE  = 2'd2,
    MODE_BOUNCE = 2'd3
  } mode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [7:0] LED_ALL_OFF = 8'h00;
  localparam logic [7:0] LED_ALL_ON  = 8'hFF;
  localparam logic [7:0] LED_SEED    = 8'h01;

  typedef struct packed {
    logic [7:0] led;
    logic       dir_right;
  } pat_t;

  function automatic logic [7:0] seed_for(input mode_t m);
    logic [7:0] s;
    case (m)
      MODE_BLINK:  s = LED_ALL_ON;
      MODE_CHASE:  s = LED_SEED;
      MODE_BOUNCE: s = LED_SEED;
      default:     s = LED_ALL_OFF;
    endcase
    return s;
  endfunction

  // BOUNCE flips direction on the step that leaves an end, so each end value
  // is displayed for exactly one step.
  function automatic pat_t next_pattern(input mode_t m, input logic [7:0] cur,
                                        input logic dir_right);
    pat_t n;
    n.led       = cur;
    n.dir_right = dir_right;
    case (m)
      MODE_BLINK: n.led = ~cur;
      MODE_CHASE: n.led = {cur[6:0], cur[7]};
      MODE_BOUNCE: begin
        if (!dir_right) begin
          if (cur[7]) begin
            n.led       = cur >> 1;
            n.dir_right = 1'b1;
          end else begin
            n.led = cur << 1;
          end
        end else begin
          if (cur[0]) begin
            n.led       = cur << 1;
            n.dir_right = 1'b0;
          end else begin
            n.led = cur >> 1;
          end
        end
      end
      default: n.led = LED_ALL_OFF;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Base-tick prescaler: one tick every TICK_DIV enabled cycles, restarted by clear.
module led_tick_gen
  import led_pkg::*;
#(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = enable && !clear && (cnt == LAST);

endmodule

// File: rtl/led_seq_ctrl.sv
// LED bank sequencer: latches mode/period over a valid/ready handshake and
// steps the selected pattern every TICK_DIV*period cycles while running.
module led_seq_ctrl
  import led_pkg::*;
#(
  parameter int unsigned TICK_DIV = 4,
  parameter int unsigned PERIOD_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [1:0]          cfg_mode,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic                start,
  input  logic                stop,
  output logic [7:0]          LED,
  output logic                busy,
  output logic                step_done
);

  state_t              state;
  mode_t               mode_q;
  logic [PERIOD_W-1:0] period_q;
  logic [PERIOD_W-1:0] step_cnt;
  logic                dir_right;

  logic  cfg_take;
  mode_t mode_eff;
  logic  go;
  logic  halt;
  logic  tick_clear;
  logic  tick_en;
  logic  tick;
  logic  step;
  pat_t  nxt;

  assign cfg_ready = (state == ST_IDLE);
  assign busy      = (state == ST_RUN);

  assign cfg_take = cfg_valid && cfg_ready;
  // A config offered together with start seeds the run it starts.
  assign mode_eff = cfg_take ? mode_t'(cfg_mode) : mode_q;

  assign go         = (state == ST_IDLE) && start && !stop;
  assign halt       = (state == ST_RUN) && stop;
  assign tick_clear = (state != ST_RUN) || stop;
  assign tick_en    = (state == ST_RUN);

  led_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .clear  (tick_clear),
    .enable (tick_en),
    .tick   (tick)
  );

  assign step = tick && (step_cnt == period_q - 1'b1);
  assign nxt  = next_pattern(mode_q, LED, dir_right);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q   <= MODE_OFF;
      period_q <= PERIOD_W'(1);
    end else if (cfg_take) begin
      mode_q   <= mode_t'(cfg_mode);
      period_q <= (cfg_period == '0) ? PERIOD_W'(1) : cfg_period;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (go)   state <= ST_RUN;
        ST_RUN:  if (halt) state <= ST_IDLE;
        default:           state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_cnt <= '0;
    end else if (tick_clear) begin
      step_cnt <= '0;
    end else if (tick) begin
      step_cnt <= step ? '0 : step_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      LED       <= LED_ALL_OFF;
      dir_right <= 1'b0;
      step_done <= 1'b0;
    end else begin
      step_done <= 1'b0;
      if (go) begin
        LED       <= seed_for(mode_eff);
        dir_right <= 1'b0;
      end else if (halt) begin
        LED       <= LED_ALL_OFF;
        dir_right <= 1'b0;
      end else if (step) begin
        LED       <= nxt.led;
        dir_right <= nxt.dir_right;
        step_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl with TICK_DIV=2, PERIOD_W=8.
module tb_led_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_mode;
  logic [7:0] cfg_period;
  logic       start;
  logic       stop;
  logic [7:0] LED;
  logic       busy;
  logic       step_done;

  int tests;
  int failed;

  logic [7:0] bseq [16] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                           8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};

  led_seq_ctrl #(
    .TICK_DIV (2),
    .PERIOD_W (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_mode   (cfg_mode),
    .cfg_period (cfg_period),
    .start      (start),
    .stop       (stop),
    .LED        (LED),
    .busy       (busy),
    .step_done  (step_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic configure(input logic [1:0] m, input logic [7:0] p);
    cfg_valid  = 1'b1;
    cfg_mode   = m;
    cfg_period = p;
    @(negedge clk);
    cfg_valid  = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  initial begin
    tests = 0;
    failed = 0;
    rst = 1'b0;
    cfg_valid = 1'b0;
    cfg_mode = 2'd0;
    cfg_period = 8'd0;
    start = 1'b0;
    stop = 1'b0;

    #12;
    check("rst_led", LED, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", cfg_ready, 1'b1);
    check("rst_step", step_done, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Default config: OFF, period 1 -> step every 2 cycles.
    pulse_start();
    check("off_led", LED, 8'h00);
    check("off_busy", busy, 1'b1);
    check("off_ready", cfg_ready, 1'b0);
    check("off_sd0", step_done, 1'b0);
    @(negedge clk);
    check("off_sd1", step_done, 1'b0);
    @(negedge clk);
    check("off_sd2", step_done, 1'b1);
    check("off_led2", LED, 8'h00);
    @(negedge clk);
    check("off_sd3", step_done, 1'b0);
    @(negedge clk);
    check("off_sd4", step_done, 1'b1);
    pulse_stop();
    check("off_stop_busy", busy, 1'b0);

    // CHASE, period 3 -> step every 6 cycles, wraps after 8 steps.
    configure(2'd2, 8'd3);
    pulse_start();
    check("chase_seed", LED, 8'h01);
    for (int i = 1; i <= 8; i++) begin
      repeat (5) @(negedge clk);
      check("chase_gap", step_done, 1'b0);
      @(negedge clk);
      check("chase_sd", step_done, 1'b1);
      check("chase_led", LED, 32'((8'h01 << (i % 8))));
    end
    pulse_stop();
    check("chase_stop_led", LED, 8'h00);
    check("chase_stop_busy", busy, 1'b0);

    // BOUNCE, period 1.
    configure(2'd3, 8'd1);
    pulse_start();
    check("bounce_seed", LED, 8'h01);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("bounce_gap", step_done, 1'b0);
      @(negedge clk);
      check("bounce_led", LED, bseq[i]);
    end
    pulse_stop();

    // BLINK, period 0 (acts as 1); stop on a step cycle; cfg held during RUN.
    configure(2'd1, 8'd0);
    pulse_start();
    check("blink_seed", LED, 8'hFF);
    repeat (2) @(negedge clk);
    check("blink_t1", LED, 8'h00);
    repeat (2) @(negedge clk);
    check("blink_t2", LED, 8'hFF);
    cfg_valid = 1'b1;
    cfg_mode = 2'd2;
    cfg_period = 8'd1;
    @(negedge clk);
    check("run_ready", cfg_ready, 1'b0);
    check("blink_hold", LED, 8'hFF);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("stop_led", LED, 8'h00);
    check("stop_busy", busy, 1'b0);
    check("stop_nosd", step_done, 1'b0);
    check("stop_ready", cfg_ready, 1'b1);
    @(negedge clk);
    cfg_valid = 1'b0;
    pulse_start();
    check("held_cfg_seed", LED, 8'h01);
    repeat (2) @(negedge clk);
    check("held_cfg_step", LED, 8'h02);
    pulse_stop();

    // start+stop together in IDLE (with a BLINK config offered).
    cfg_valid = 1'b1;
    cfg_mode = 2'd1;
    cfg_period = 8'd1;
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    check("ss_busy", busy, 1'b0);
    check("ss_led", LED, 8'h00);
    // Config + start same cycle: CHASE period 2 must be used, not BLINK.
    cfg_valid = 1'b1;
    cfg_mode = 2'd2;
    cfg_period = 8'd2;
    start = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    start = 1'b0;
    check("cs_seed", LED, 8'h01);
    check("cs_busy", busy, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      repeat (3) @(negedge clk);
      check("cs_gap", step_done, 1'b0);
      @(negedge clk);
      check("cs_led", LED, 32'((8'h01 << k)));
    end

    // Asynchronous reset mid-RUN with LED=10.
    #2 rst = 1'b0;
    #1;
    check("arst_led", LED, 8'h00);
    check("arst_busy", busy, 1'b0);
    check("arst_ready", cfg_ready, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    pulse_start();
    check("arst_mode_off", LED, 8'h00);
    @(negedge clk);
    check("arst_sd1", step_done, 1'b0);
    @(negedge clk);
    check("arst_period1", step_done, 1'b1);
    pulse_stop();

    // Maximum period 255 -> first step 510 cycles after the seed edge.
    configure(2'd0, 8'd255);
    pulse_start();
    repeat (508) @(negedge clk);
    check("p255_early", step_done, 1'b0);
    @(negedge clk);
    check("p255_early1", step_done, 1'b0);
    @(negedge clk);
    check("p255_step", step_done, 1'b1);
    pulse_stop();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/led_seq_ctrl.md
Name: led_seq_ctrl

Overview:
- Controller that sequences the 8-LED bank through selectable display patterns at a programmable step rate.
- Sits between a host/config source and the LED pins.
- Accepts a configuration via a valid/ready handshake, then runs the pattern on start until stopped.
- Replaces the free-running on/off blinker with a configurable scheduler.

Parameters:
- TICK_DIV, 4: clk cycles per base tick (prescaler); legal range ≥1.
- PERIOD_W, 8: width of the cfg_period field.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst  in  1  reset; asynchronous assert, active-low.
- cfg_valid  in  1  configuration offered.
- cfg_ready  out  1  configuration can be accepted; high only in IDLE.
- cfg_mode  in  2  pattern select: 0 OFF, 1 BLINK, 2 CHASE, 3 BOUNCE.
- cfg_period  in  PERIOD_W  base ticks per pattern step; 0 treated as 1.
- start  in  1  single-cycle request to begin running.
- stop  in  1  single-cycle request to halt.
- LED  out  8  LED drive.
- busy  out  1  high while in RUN.
- step_done  out  1  one-cycle pulse on every pattern step.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst=0):
  - State=IDLE; LED=8'h00; busy=0; step_done=0; cfg_ready=1.
  - Latched mode=OFF; latched period=1; prescaler, step counter and BOUNCE direction all cleared.
- Reset mid-RUN: outputs return to reset values immediately (asynchronous). Latched config is lost.
- Config handshake:
  - Transfer occurs when cfg_valid && cfg_ready.
  - mode and period are latched at that edge.
  - cfg_valid in RUN is ignored (cfg_ready=0); the source must hold it until IDLE.
- FSM, states IDLE and RUN:
  - IDLE -> RUN on start && !stop.
  - RUN -> IDLE on stop.
  - start in RUN is ignored.
  - start && stop in the same cycle: stop wins; stay in or go to IDLE.
  - Config and start in the same cycle in IDLE: the new config is used for that run.
- Entering RUN:
  - Prescaler and step counter cleared.
  - LED loads the pattern seed on the next edge: OFF 8'h00, BLINK 8'hFF, CHASE 8'h01, BOUNCE 8'h01 with direction=left.
  - busy=1 from the same edge.
- Timing:
  - Prescaler counts 0..TICK_DIV-1 and emits a tick when at TICK_DIV-1.
  - Step counter counts ticks 0..P-1 (P = max(cfg_period,1)); a step fires on the tick where the counter equals P-1.
  - Consecutive steps are exactly TICK_DIV*P cycles apart. The first step is TICK_DIV*P cycles after the seed edge.
- Step actions (LED updates on the step edge; step_done high for that one cycle):
  - OFF: LED stays 8'h00; step_done still pulses.
  - BLINK: LED toggles 8'hFF <-> 8'h00.
  - CHASE: rotate left; 8'h80 -> 8'h01.
  - BOUNCE: shift toward the current direction; reverse at ends.
    - Sequence 01,02,...,80,40,...,01,02...
    - Each end value is shown for exactly one step.
- Stop: LED=8'h00, busy=0 and counters cleared on the edge stop is sampled. No step_done on that cycle even if a step coincides.
- Period arithmetic: step counter is PERIOD_W bits. Period 0 and period 1 behave identically; period 2^PERIOD_W-1 is the maximum with no overflow.

Decomposition:
- Shared package led_pkg:
  - Mode enum (MODE_OFF/BLINK/CHASE/BOUNCE).
  - FSM state enum (ST_IDLE/ST_RUN).
  - Seed constants LED_ALL_OFF=8'h00, LED_ALL_ON=8'hFF, LED_SEED=8'h01.
- One sub-module led_tick_gen:
  - Parameterised by TICK_DIV.
  - Inputs: clk, rst, clear, enable. Output: tick.

Test Plan (TICK_DIV=2):
- Reset check: assert rst=0 mid-simulation -> LED=00, busy=0, cfg_ready=1 immediately; after release, start with no config -> LED=00, step_done every 2 cycles (mode OFF, period 1).
- Config mode=CHASE, period=3, then start -> LED=01 next edge, then 02 after 6 cycles, 04 after 12; after 8 steps LED wraps 80 -> 01; step_done pulses are 6 cycles apart.
- Config mode=BOUNCE, period=1, start -> LED sequence 01,02,04,08,10,20,40,80,40,20,...,01,02 at 2-cycle spacing.
- Config mode=BLINK, period=0, start -> FF then toggles every 2 cycles. Assert stop -> LED=00 and busy=0 next edge, no step_done that cycle. cfg_valid held during RUN is accepted only after return to IDLE.
- Same cycle in IDLE: start+stop -> stays IDLE, LED=00. cfg_valid (mode=CHASE) + start -> RUN with LED=01.
- Reset asserted mid-RUN with LED=10 -> LED=00 asynchronously; latched config reverts to OFF/period 1.
